// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared types and constants for the SRAM data-memory
//                controller (FSM state encoding, default timing, bus width).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

   localparam int C_DEF_WAIT_CYCLES = 5;
   localparam int C_DEF_BASE_ADDR   = 1024;
   localparam int C_SRAM_DW         = 16;

   // LO/HI are the two 16-bit halves of one 32-bit CPU access
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wait_counter
//  Description : Counts the clocks of one 16-bit SRAM access. 'last' flags
//                the final cycle of the access; the count wraps to zero on
//                that cycle so the next half starts cleanly.
//  Revision    : 1.0 - initial release
// ============================================================================
module wait_counter #(
   parameter int WAIT_CYCLES = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic last
);

   localparam int            CW     = $clog2(WAIT_CYCLES + 1);
   localparam logic [CW-1:0] C_LAST = CW'(WAIT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic          w_at_last;

   assign w_at_last = (cnt_q == C_LAST);

   // cycle counter: cleared outside an access, wraps after the final cycle
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= w_at_last ? '0 : cnt_q + CW'(1);
      end
   end

   assign last = enable && w_at_last;

endmodule
`default_nettype wire

// File: rtl/sram_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_mem_ctrl
//  Description : MEM-stage data memory controller for a 16-bit SRAM. Each
//                32-bit load/store becomes two 16-bit SRAM accesses (low
//                half then high half) of WAIT_CYCLES clocks each; ready and
//                freeze hold the pipeline until the access completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = C_DEF_WAIT_CYCLES,
   parameter int BASE_ADDR   = C_DEF_BASE_ADDR,
   parameter int SRAM_AW     = 18
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_en,
   input  logic                 wr_en,
   input  logic [31:0]          addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   output logic                 ready,
   output logic                 freeze,
   output logic [SRAM_AW-1:0]   sram_addr,
   output logic [C_SRAM_DW-1:0] sram_dq_out,
   output logic                 sram_dq_oe,
   input  logic [C_SRAM_DW-1:0] sram_dq_in,
   output logic                 sram_we_n
);

   // one 32-bit word spans two SRAM locations, so the word index is one bit
   // narrower than the SRAM address
   localparam int WW = SRAM_AW - 1;

   state_t                 state_q;
   logic [WW-1:0]          word_q;
   logic [WW-1:0]          word_d;
   logic [31:0]            wdata_q;
   logic                   is_wr_q;
   logic [31:0]            rdata_q;
   logic [SRAM_AW-1:0]     sram_addr_q;
   logic [C_SRAM_DW-1:0]   dq_out_q;
   logic                   dq_oe_q;
   logic                   we_n_q;

   logic                   w_req;
   logic                   w_busy;
   logic                   w_last;
   logic                   w_ready;

   assign w_req  = rd_en | wr_en;
   assign w_busy = (state_q == LO) || (state_q == HI);

   // byte address relative to the SRAM window, dropped to a word index;
   // addresses below BASE_ADDR wrap around the SRAM
   assign word_d = WW'((addr - 32'(BASE_ADDR)) >> 2);

   wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (!w_busy),
      .enable (w_busy),
      .last   (w_last)
   );

   // access sequencer; SRAM pins are registered alongside the state so they
   // change on the same edge as the state they belong to
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         word_q      <= '0;
         wdata_q     <= '0;
         is_wr_q     <= 1'b0;
         rdata_q     <= '0;
         sram_addr_q <= '0;
         dq_out_q    <= '0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (w_req) begin
                  // a simultaneous load and store is performed as a store
                  state_q     <= LO;
                  word_q      <= word_d;
                  wdata_q     <= wdata;
                  is_wr_q     <= wr_en;
                  sram_addr_q <= {word_d, 1'b0};
                  dq_out_q    <= wr_en ? wdata[15:0] : '0;
                  dq_oe_q     <= wr_en;
                  we_n_q      <= !wr_en;
               end
            end
            LO: begin
               if (w_last) begin
                  if (!is_wr_q) begin
                     rdata_q[15:0] <= sram_dq_in;
                  end
                  state_q     <= HI;
                  sram_addr_q <= {word_q, 1'b1};
                  dq_out_q    <= is_wr_q ? wdata_q[31:16] : '0;
               end
            end
            HI: begin
               if (w_last) begin
                  if (!is_wr_q) begin
                     rdata_q[31:16] <= sram_dq_in;
                  end
                  state_q  <= DONE;
                  dq_out_q <= '0;
                  dq_oe_q  <= 1'b0;
                  we_n_q   <= 1'b1;
               end
            end
            default: begin
               // DONE lasts one cycle; a held request starts a new access
               state_q <= IDLE;
            end
         endcase
      end
   end

   // pipeline handshake: released when idle with nothing asked, or when done
   assign w_ready = ((state_q == IDLE) && !w_req) || (state_q == DONE);

   assign ready       = w_ready;
   assign freeze      = !w_ready;
   assign rdata       = rdata_q;
   assign sram_addr   = sram_addr_q;
   assign sram_dq_out = dq_out_q;
   assign sram_dq_oe  = dq_oe_q;
   assign sram_we_n   = we_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_mem_ctrl
//  Description : Self-checking bench for sram_mem_ctrl with a behavioural
//                16-bit SRAM, a reference memory and a read-data scoreboard.
//                A second instance runs with WAIT_CYCLES=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_mem_ctrl;

   localparam int W    = 5;
   localparam int BASE = 1024;
   localparam int AW   = 18;

   logic          clk;
   logic          rst;

   logic          rd_en, wr_en;
   logic [31:0]   addr, wdata, rdata;
   logic          ready, freeze;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_out, sram_dq_in;
   logic          sram_dq_oe, sram_we_n;

   logic          rd1, wr1;
   logic [31:0]   addr1, wdata1, rdata1;
   logic          ready1, freeze1;
   logic [AW-1:0] sram_addr1;
   logic [15:0]   sram_dq_out1, sram_dq_in1;
   logic          sram_dq_oe1, sram_we_n1;

   logic [15:0]   mem  [0:(1<<AW)-1];
   logic [15:0]   mem1 [0:(1<<AW)-1];
   logic [15:0]   refm [logic [AW-1:0]];
   logic [31:0]   sb_q [$];

   int            n_tests;
   int            n_fail;

   sram_mem_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
      .wdata(wdata), .rdata(rdata), .ready(ready), .freeze(freeze),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
   );

   sram_mem_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(BASE), .SRAM_AW(AW)) dut1 (
      .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1), .addr(addr1),
      .wdata(wdata1), .rdata(rdata1), .ready(ready1), .freeze(freeze1),
      .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_oe(sram_dq_oe1),
      .sram_dq_in(sram_dq_in1), .sram_we_n(sram_we_n1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // asynchronous-read SRAM models, written on the clock while we_n is low
   assign sram_dq_in  = mem[sram_addr];
   assign sram_dq_in1 = mem1[sram_addr1];

   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
      if (!sram_we_n1 && sram_dq_oe1) mem1[sram_addr1] <= sram_dq_out1;
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input logic [AW-2:0] w);
      logic [15:0] lo, hi;
      lo = refm.exists({w, 1'b0}) ? refm[{w, 1'b0}] : 16'h0;
      hi = refm.exists({w, 1'b1}) ? refm[{w, 1'b1}] : 16'h0;
      return {hi, lo};
   endfunction

   // one access on the W=5 instance; starts just after a rising edge
   task automatic run_access(input string tag, input logic rd, input logic wr,
                             input logic [31:0] a, input logic [31:0] d,
                             input bit hold, input bit scramble, output int lat);
      logic [AW-2:0] w;
      logic [31:0]   exp;
      bit            iswr;
      int            errs, welo;
      iswr = wr;
      w    = (AW-1)'((a - 32'(BASE)) >> 2);
      rd_en = rd; wr_en = wr; addr = a; wdata = d;
      if (!iswr) sb_q.push_back(ref_word(w));
      errs = 0; welo = 0; lat = -1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (ready) begin
            lat = k;
            break;
         end
         if (k >= 1 && k <= 2*W) begin
            bit hi;
            hi = (k > W);
            if (sram_addr !== {w, hi}) errs++;
            if (sram_we_n !== !iswr) errs++;
            if (sram_dq_oe !== iswr) errs++;
            if (sram_dq_out !== (iswr ? (hi ? d[31:16] : d[15:0]) : 16'h0)) errs++;
            if (!sram_we_n) welo++;
         end
         @(posedge clk); #1;
         if (scramble && (k == 1 || k == W+1)) begin
            addr  = $urandom;
            wdata = $urandom;
         end
      end
      check_value({tag, "_lat"}, lat, 2*W+1);
      check_value({tag, "_seq"}, errs, 0);
      check_value({tag, "_welo"}, welo, iswr ? 2*W : 0);
      if (iswr) begin
         refm[{w, 1'b0}] = d[15:0];
         refm[{w, 1'b1}] = d[31:16];
         check_value({tag, "_mlo"}, {16'h0, mem[{w, 1'b0}]}, {16'h0, d[15:0]});
         check_value({tag, "_mhi"}, {16'h0, mem[{w, 1'b1}]}, {16'h0, d[31:16]});
      end else begin
         exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
         check_value({tag, "_rdata"}, rdata, exp);
      end
      @(posedge clk); #1;
      if (!hold) begin
         rd_en = 1'b0;
         wr_en = 1'b0;
      end
   endtask

   // one access on the WAIT_CYCLES=1 instance
   task automatic run_w1(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int lat);
      rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d; lat = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (ready1) begin
            lat = k;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      rd1 = 1'b0;
      wr1 = 1'b0;
   endtask

   initial begin
      int lat_a, lat_b, errs;
      logic [31:0] exp1;
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < (1<<AW); i++) begin
         mem[i]  = 16'h0;
         mem1[i] = 16'h0;
      end
      rst = 1'b1;
      rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0;
      rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_value("rst_ready", ready, 1);
      check_value("rst_freeze", freeze, 0);
      check_value("rst_we_n", sram_we_n, 1);
      check_value("rst_oe", sram_dq_oe, 0);
      check_value("rst_addr", sram_addr, 0);
      check_value("rst_dq_out", sram_dq_out, 0);
      check_value("rst_rdata", rdata, 0);
      rd_en = 1'b1;
      #1;
      check_value("rst_req_ready", ready, 0);
      check_value("rst_req_freeze", freeze, 1);
      rd_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // idle with no request
      errs = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ready !== 1'b1 || freeze !== 1'b0 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) errs++;
         @(posedge clk); #1;
      end
      check_value("idle", errs, 0);

      run_access("wr1024", 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0, 1'b0, lat_a);
      run_access("rd1024", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b0, lat_a);
      run_access("wr1028", 1'b0, 1'b1, 32'd1028, 32'hCAFE0001, 1'b0, 1'b0, lat_a);
      run_access("rd1031", 1'b1, 1'b0, 32'd1031, 32'h0, 1'b0, 1'b0, lat_a);

      // back-to-back loads with rd_en held through DONE
      run_access("b2b_a", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, 1'b0, lat_a);
      run_access("b2b_b", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, 1'b0, lat_b);
      check_value("b2b_total", lat_a + 1 + lat_b, 4*W+3);

      // reset during the second HI cycle of a store
      wr_en = 1'b1; addr = 32'd1040; wdata = 32'h11112222;
      repeat (W+2) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      wr_en = 1'b0;
      @(negedge clk);
      check_value("mrst_we_n", sram_we_n, 1);
      check_value("mrst_oe", sram_dq_oe, 0);
      check_value("mrst_rdata", rdata, 0);
      check_value("mrst_ready", ready, 1);
      @(posedge clk); #1;
      run_access("rd_after_rst", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, 1'b0, lat_a);

      // load and store together act as a store
      run_access("both", 1'b1, 1'b1, 32'd1036, 32'h0BADF00D, 1'b0, 1'b0, lat_a);
      run_access("rd_both", 1'b1, 1'b0, 32'd1036, 32'h0, 1'b0, 1'b0, lat_a);

      // request inputs disturbed mid-access
      run_access("scr_wr", 1'b0, 1'b1, 32'd1044, 32'h13579BDF, 1'b0, 1'b1, lat_a);
      run_access("scr_rd", 1'b1, 1'b0, 32'd1044, 32'h0, 1'b0, 1'b1, lat_a);

      // address below the window wraps around the SRAM
      run_access("wrap_wr", 1'b0, 1'b1, 32'd0, 32'hA5A55A5A, 1'b0, 1'b0, lat_a);
      run_access("wrap_rd", 1'b1, 1'b0, 32'd0, 32'h0, 1'b0, 1'b0, lat_a);

      // WAIT_CYCLES = 1 instance
      run_w1(1'b0, 1'b1, 32'd1032, 32'h12345678, lat_a);
      check_value("w1_wr_lat", lat_a, 3);
      check_value("w1_mlo", {16'h0, mem1[4]}, 32'h5678);
      check_value("w1_mhi", {16'h0, mem1[5]}, 32'h1234);
      sb_q.push_back(32'h12345678);
      run_w1(1'b1, 1'b0, 32'd1032, 32'h0, lat_b);
      check_value("w1_rd_lat", lat_b, 3);
      exp1 = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hxxxx_xxxx;
      check_value("w1_rdata", rdata1, exp1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Multi-cycle controller for the MEM stage's data memory; sits between MEM-stage control (rd_en/wr_en, ALU result as address, store data) and a 16-bit external SRAM.
- Each 32-bit CPU access is split into two 16-bit SRAM accesses (low half, then high half), each lasting WAIT_CYCLES clocks.
- Drives ready/freeze so the pipeline registers (including the MEM/WB register) hold until the access completes.

Parameters:
- WAIT_CYCLES, 5, clocks per 16-bit SRAM access (legal range ≥1).
- BASE_ADDR, 1024, CPU byte address mapped to SRAM word 0.
- SRAM_AW, 18, SRAM address width (16-bit locations).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  MEM-stage load request; held until ready.
- wr_en  in  1  MEM-stage store request; held until ready.
- addr  in  32  CPU byte address (ALU result).
- wdata  in  32  store data.
- rdata  out  32  load data; valid while ready=1 in DONE.
- ready  out  1  access complete, or no request pending.
- freeze  out  1  equals !ready; stalls pipeline registers.
- sram_addr  out  SRAM_AW  SRAM location address.
- sram_dq_out  out  16  SRAM write data.
- sram_dq_oe  out  1  SRAM data-bus drive enable.
- sram_dq_in  in  16  SRAM read data.
- sram_we_n  out  1  SRAM write enable, active low.

Behaviour:
- Interface rule: one clock (clk); reset rst is synchronous and active-high. The polarity and synchronicity are fixed.
- States: IDLE, LO, HI, DONE.
- req = rd_en | wr_en. When both are high, the access is treated as a write.
- IDLE:
  - If req, latch the access on this edge: word = (addr − BASE_ADDR) >> 2, truncated modulo 2^(SRAM_AW−1); wdata; is_write. Go to LO with cnt=0.
  - Otherwise stay in IDLE.
- LO:
  - sram_addr = {word, 1'b0}.
  - cnt increments each clock.
  - On cnt == WAIT_CYCLES−1: for a read, rdata[15:0] <= sram_dq_in. Go to HI with cnt=0.
- HI:
  - sram_addr = {word, 1'b1}.
  - On cnt == WAIT_CYCLES−1: for a read, rdata[31:16] <= sram_dq_in. Go to DONE.
- DONE: lasts exactly one cycle, then IDLE unconditionally. A req seen in the following IDLE cycle is a new access.
- ready = (state==IDLE && !req) || state==DONE. It is combinational; ready is never asserted in LO or HI.
- Writes:
  - sram_we_n = 0 and sram_dq_oe = 1 throughout LO and HI.
  - sram_dq_out = wdata[15:0] in LO, wdata[31:16] in HI.
  - Otherwise sram_we_n = 1, sram_dq_oe = 0, sram_dq_out = 0.
- Reads: sram_we_n = 1 and sram_dq_oe = 0 throughout.
- Latency: request first seen in IDLE at cycle 0 → LO for cycles 1..W → HI for W+1..2W → DONE (ready=1) at cycle 2W+1. For W=5, ready arrives at cycle 11.
- Requests changing during LO/HI are ignored; the latched values are used.
- Reset values:
  - state = IDLE, cnt = 0, rdata = 0, latched word/wdata = 0.
  - Outputs: sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0.
  - ready = !req, freeze = req.
- Reset mid-access: abandon the access at once. The SRAM sees we_n = 1 on the next cycle. A write may leave only its low half written; this is accepted.
- Address below BASE_ADDR wraps modulo the SRAM size; no error is flagged. addr[1:0] is ignored.

Decomposition:
- Shared package mem_ctrl_pkg:
  - state enum {IDLE, LO, HI, DONE};
  - defaults for BASE_ADDR and WAIT_CYCLES;
  - SRAM data width constant 16.
- One sub-module, wait_counter:
  - parameter WAIT_CYCLES; inputs clk, rst, clear, enable; output last.
  - Counter width is $clog2(WAIT_CYCLES+1).

Test Plan:
- Write then read, W=5: wr_en, addr=1024, wdata=0xDEADBEEF → SRAM location 0 written 0xBEEF and location 1 written 0xDEAD; we_n low for 10 cycles; ready at cycle 11. Then rd_en, addr=1024, with the SRAM model returning the stored data → rdata=0xDEADBEEF at ready.
- Address mapping: addr=1028 → sram_addr 2, then 3. addr=1031 → same 2/3 (low bits ignored).
- Idle behaviour: rd_en=wr_en=0 → ready=1, freeze=0, we_n=1, dq_oe=0 indefinitely.
- Back-to-back loads with rd_en held high: DONE lasts one cycle; the next access starts from IDLE → second ready at cycle 2·(2W+2)−1 = 23 from the first request.
- Reset mid-write: rst during HI cycle 2 → next cycle IDLE, we_n=1, dq_oe=0, rdata=0; a subsequent read completes normally.
- Mid-access changes and WAIT_CYCLES=1:
  - Changing addr/wdata during LO/HI has no effect on the SRAM transaction.
  - Both rd_en and wr_en high → the access is performed as a write.
  - With WAIT_CYCLES=1, ready arrives at cycle 3.
